video_mode_sched: RTL and testbench

Mode scheduler for the Mega Drive video conditioning path. It measures live VDP output: active pixels per line, plus the mode bits and field flag sampled at vsync. It debounces the measured mode over several frames and commits a new resolution/border/correction configuration only at a frame boundary. The conditioning datapath and aspect-ratio logic downstream never see a mid-frame or glitch-induced mode change.

---
 rtl/video_cond_pkg.sv | 47 ++++
 rtl/video_mode_sched_if.sv | 34 +++
 rtl/video_mode_sched_line_meter.sv | 67 ++++++
 rtl/video_mode_sched.sv | 122 ++++++++++++
 tb/tb_video_mode_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_cond_pkg.sv
// rtl/video_cond_pkg.sv - shared types, thresholds and classifier for the video mode scheduler
package video_cond_pkg;

  // Horizontal mode as seen by the conditioning datapath.
  typedef enum logic [1:0] {
    RES_H_248    = 2'd0,
    RES_H_256    = 2'd1,
    RES_H_320    = 2'd2,
    RES_H_320COR = 2'd3
  } res_h_t;

  // Vertical mode derived from the VDP M5/M2 bits.
  typedef enum logic [1:0] {
    RES_V_192 = 2'd0,
    RES_V_224 = 2'd1,
    RES_V_240 = 2'd2
  } res_v_t;

  // Active-pixel thresholds separating H40 / H32 / narrow modes.
  localparam int H_THR_320 = 300;
  localparam int H_THR_256 = 252;

  // One frame's worth of measured configuration.
  typedef struct packed {
    res_h_t res_h;
    res_v_t res_v;
    logic   border;
  } cand_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_COMMIT = 2'd2
  } sched_state_t;

  // Classify the widest active line of a frame into a horizontal mode.
  function automatic res_h_t classify_h(input logic [15:0] px, input logic corr);
    if (px > 16'(H_THR_320)) begin
      return corr ? RES_H_320COR : RES_H_320;
    end else if (px > 16'(H_THR_256)) begin
      return RES_H_256;
    end else begin
      return RES_H_248;
    end
  endfunction

endpackage

// File: rtl/video_mode_sched_if.sv
// rtl/video_mode_sched_if.sv - VDP measurement inputs and committed mode outputs
interface video_mode_sched_if;
  logic       ce_pix;
  logic       vdp_de_h;
  logic       vdp_de_v;
  logic       hs_in;
  logic       vs_in;
  logic       vdp_intfield;
  logic       vdp_m2;
  logic       vdp_m5;
  logic       border_req;
  logic       h40corr_req;
  logic [1:0] res_h;
  logic [1:0] res_v;
  logic       border_en;
  logic       interlace;
  logic       f1;
  logic       commit;
  logic       locked;

  // Video source / OSD side: drives the VDP timing and requests, reads the committed mode.
  modport master (
    output ce_pix, vdp_de_h, vdp_de_v, hs_in, vs_in, vdp_intfield,
           vdp_m2, vdp_m5, border_req, h40corr_req,
    input  res_h, res_v, border_en, interlace, f1, commit, locked
  );

  // Scheduler side.
  modport slave (
    input  ce_pix, vdp_de_h, vdp_de_v, hs_in, vs_in, vdp_intfield,
           vdp_m2, vdp_m5, border_req, h40corr_req,
    output res_h, res_v, border_en, interlace, f1, commit, locked
  );
endinterface

// File: rtl/video_mode_sched_line_meter.sv
// rtl/video_mode_sched_line_meter.sv - sync edge detect and widest-active-line measurement
module vid_line_meter #(
  parameter int PCNT_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              de_h,
  input  logic              de_v,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              line_end,
  output logic              frame_end,
  output logic [PCNT_W-1:0] line_max
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  logic              hs_d;
  logic              vs_d;
  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] max_q;
  logic              fold;

  // Falling edges of the active-low syncs mark line and frame boundaries.
  assign line_end  = hs_d & ~hs_in;
  assign frame_end = vs_d & ~vs_in;

  // The line finishing this cycle is folded in combinationally, so a line_end
  // coincident with frame_end still contributes to the frame's classification.
  assign fold     = line_end & de_v & (pcnt > max_q);
  assign line_max = fold ? pcnt : max_q;

  // Registered sync copies; cleared low so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_d <= hs_in;
      vs_d <= vs_in;
    end
  end

  // Saturating per-line pixel counter; the line_end clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (line_end) begin
      pcnt <= '0;
    end else if (de_h && ce_pix && (pcnt != PCNT_MAX)) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Widest active line of the current frame, restarted at every frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
    end else if (frame_end) begin
      max_q <= '0;
    end else begin
      max_q <= line_max;
    end
  end

endmodule

// File: rtl/video_mode_sched.sv
// rtl/video_mode_sched.sv - debounced frame-boundary mode scheduler for the VDP conditioning path
module video_mode_sched #(
  parameter int STABLE_FRAMES = 3,
  parameter int PCNT_W        = 9
) (
  input  logic               clk,
  input  logic               reset,
  video_mode_sched_if.slave  vif
);
  import video_cond_pkg::*;

  localparam logic [3:0] STAB_N = 4'(STABLE_FRAMES);

  logic              line_end;
  logic              frame_end;
  logic [PCNT_W-1:0] line_max;
  logic              meter_unused;

  sched_state_t state;
  cand_t        cand;
  cand_t        prev_cand;
  cand_t        committed;
  logic [3:0]   stab_cnt;
  logic [3:0]   stab_next;
  logic         blank;
  logic         f1_q;
  logic         interlace_q;
  logic         commit_q;
  logic         locked_q;

  vid_line_meter #(
    .PCNT_W (PCNT_W)
  ) u_meter (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (vif.ce_pix),
    .de_h      (vif.vdp_de_h),
    .de_v      (vif.vdp_de_v),
    .hs_in     (vif.hs_in),
    .vs_in     (vif.vs_in),
    .line_end  (line_end),
    .frame_end (frame_end),
    .line_max  (line_max)
  );

  // Line boundaries are consumed inside the meter; the scheduler acts only on frame_end.
  assign meter_unused = line_end;

  // Frames with no active pixels at all carry no mode information.
  assign blank = (line_max == '0);

  // Candidate configuration for the frame ending now.
  always_comb begin
    cand        = '0;
    cand.res_h  = classify_h(16'(line_max), vif.h40corr_req);
    cand.res_v  = !vif.vdp_m5 ? RES_V_192 : (!vif.vdp_m2 ? RES_V_224 : RES_V_240);
    cand.border = vif.border_req;
  end

  // Stability count after this frame: extend a run of identical frames, else restart at 1.
  always_comb begin
    stab_next = 4'd1;
    if (cand == prev_cand) begin
      stab_next = (stab_cnt >= STAB_N) ? STAB_N : stab_cnt + 4'd1;
    end
  end

  // Scheduler FSM with all outputs registered; commits only in the cycle after frame_end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_cand   <= '0;
      committed   <= '0;
      stab_cnt    <= '0;
      f1_q        <= 1'b0;
      interlace_q <= 1'b0;
      commit_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      locked_q <= (stab_cnt >= STAB_N) && (prev_cand == committed);
      unique case (state)
        // The frame in progress at reset is partial: its end only arms tracking.
        ST_IDLE: begin
          if (frame_end) begin
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (frame_end && !blank) begin
            stab_cnt    <= stab_next;
            prev_cand   <= cand;
            f1_q        <= vif.vdp_intfield;
            interlace_q <= f1_q ^ vif.vdp_intfield;
            if ((stab_next >= STAB_N) && (cand != committed)) begin
              state <= ST_COMMIT;
            end
          end
        end
        // One-cycle load of the debounced candidate; a frame_end cannot land here
        // because frames are many cycles apart.
        ST_COMMIT: begin
          committed <= prev_cand;
          commit_q  <= 1'b1;
          state     <= ST_TRACK;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vif.res_h     = committed.res_h;
  assign vif.res_v     = committed.res_v;
  assign vif.border_en = committed.border;
  assign vif.interlace = interlace_q;
  assign vif.f1        = f1_q;
  assign vif.commit    = commit_q;
  assign vif.locked    = locked_q;

endmodule

// File: tb/tb_video_mode_sched.sv
// tb/tb_video_mode_sched.sv - directed self-checking bench for video_mode_sched
module tb_video_mode_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic       c1, c2, c3, lk3;
  logic [1:0] rh_pre, rh2, rv2;
  logic       b2;
  logic [8:0] rst_snap;

  video_mode_sched_if vif();

  video_mode_sched #(
    .STABLE_FRAMES (3),
    .PCNT_W        (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vs_in has just fallen: record commit/outputs 1, 2 and 3 cycles later.
  task automatic capture_vs();
    rh_pre = vif.res_h;
    step();
    c1 = vif.commit;
    step();
    c2  = vif.commit;
    rh2 = vif.res_h;
    rv2 = vif.res_v;
    b2  = vif.border_en;
    step();
    c3  = vif.commit;
    lk3 = vif.locked;
  endtask

  // One frame: nlines active lines (last one last_pix wide), optional hs/vs
  // coincidence on the last line, optional one-cycle reset during line 0.
  task automatic drive_frame(input int npix, input int nlines, input int last_pix,
                             input bit coincide, input int rst_at);
    int n;
    vif.vdp_de_v = 1'b1;
    for (int l = 0; l < nlines; l++) begin
      n = (l == nlines - 1) ? last_pix : npix;
      for (int p = 0; p < n; p++) begin
        vif.vdp_de_h = 1'b1;
        vif.ce_pix   = 1'b1;
        reset        = (l == 0 && p == rst_at);
        step();
        if (reset) begin
          rst_snap = {vif.res_h, vif.res_v, vif.border_en, vif.interlace,
                      vif.f1, vif.commit, vif.locked};
          reset = 1'b0;
        end
      end
      vif.ce_pix = 1'b0;
      step();
      vif.vdp_de_h = 1'b0;
      step();
      if (coincide && l == nlines - 1) begin
        vif.hs_in = 1'b0;
        vif.vs_in = 1'b0;
        capture_vs();
        vif.hs_in = 1'b1;
      end else begin
        vif.hs_in = 1'b0;
        step();
        step();
        vif.hs_in = 1'b1;
        step();
      end
    end
    vif.vdp_de_v = 1'b0;
    if (!coincide) begin
      vif.vs_in = 1'b0;
      capture_vs();
    end
    vif.vs_in = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({vif.res_h, vif.res_v, vif.border_en, vif.interlace, vif.f1, vif.commit, vif.locked} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {vif.res_h, vif.res_v, vif.border_en,
               vif.interlace, vif.f1, vif.commit, vif.locked});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_h40_lock();
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0) begin errors++; $display("FAIL h40_idle_drop: commit=%0d expected 0", c2); end
    drive_frame(320, 3, 320, 1'b0, -1);
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0 || rh2 !== 2'd0) begin
      errors++; $display("FAIL h40_early: commit=%0d res_h=%0d expected 0/0", c2, rh2);
    end
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if ({c1, c2, c3} !== 3'b010) begin
      errors++; $display("FAIL h40_commit_timing: c1c2c3=%b expected 010", {c1, c2, c3});
    end
    checks++;
    if (rh2 !== 2'd2 || rv2 !== 2'd2 || b2 !== 1'b0) begin
      errors++; $display("FAIL h40_values: res_h=%0d res_v=%0d border=%0d expected 2/2/0", rh2, rv2, b2);
    end
    checks++;
    if (lk3 !== 1'b1) begin errors++; $display("FAIL h40_locked: got %0d expected 1", lk3); end
  endtask

  task automatic test_h32_interleave();
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (lk3 !== 1'b0 || rh2 !== 2'd2) begin
      errors++; $display("FAIL h32_first: locked=%0d res_h=%0d expected 0/2", lk3, rh2);
    end
    drive_frame(320, 3, 320, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0 || rh2 !== 2'd2) begin
      errors++; $display("FAIL h32_restart: commit=%0d res_h=%0d expected 0/2", c2, rh2);
    end
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (rh_pre !== 2'd2 || c2 !== 1'b1 || rh2 !== 2'd1) begin
      errors++; $display("FAIL h32_commit: pre=%0d commit=%0d res_h=%0d expected 2/1/1", rh_pre, c2, rh2);
    end
  endtask

  task automatic test_h40corr();
    vif.h40corr_req = 1'b1;
    drive_frame(320, 3, 320, 1'b0, -1);
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (rh2 !== 2'd1) begin errors++; $display("FAIL corr_early: res_h=%0d expected 1", rh2); end
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd3) begin
      errors++; $display("FAIL corr_on: commit=%0d res_h=%0d expected 1/3", c2, rh2);
    end
    vif.h40corr_req = 1'b0;
    drive_frame(320, 3, 320, 1'b0, -1);
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (rh2 !== 2'd3) begin errors++; $display("FAIL corr_off_early: res_h=%0d expected 3", rh2); end
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd2) begin
      errors++; $display("FAIL corr_off: commit=%0d res_h=%0d expected 1/2", c2, rh2);
    end
  endtask

  task automatic test_blank_interlace();
    vif.vdp_intfield = 1'b0;
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (vif.f1 !== 1'b0 || vif.interlace !== 1'b0) begin
      errors++; $display("FAIL field_first: f1=%0d interlace=%0d expected 0/0", vif.f1, vif.interlace);
    end
    vif.vdp_intfield = 1'b1;
    drive_frame(320, 3, 320, 1'b0, -1);
    checks++;
    if (vif.f1 !== 1'b1 || vif.interlace !== 1'b1) begin
      errors++; $display("FAIL field_second: f1=%0d interlace=%0d expected 1/1", vif.f1, vif.interlace);
    end
    vif.vdp_intfield = 1'b0;
    drive_frame(0, 3, 0, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0 || lk3 !== 1'b1 || vif.f1 !== 1'b1 || vif.interlace !== 1'b1) begin
      errors++; $display("FAIL blank_ignored: commit=%0d locked=%0d f1=%0d interlace=%0d expected 0/1/1/1",
                         c2, lk3, vif.f1, vif.interlace);
    end
    drive_frame(256, 3, 256, 1'b0, -1);
    drive_frame(0, 3, 0, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0 || rh2 !== 2'd2) begin
      errors++; $display("FAIL blank_hold_early: commit=%0d res_h=%0d expected 0/2", c2, rh2);
    end
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd1) begin
      errors++; $display("FAIL blank_hold_commit: commit=%0d res_h=%0d expected 1/1", c2, rh2);
    end
  endtask

  task automatic test_boundary();
    drive_frame(256, 3, 320, 1'b1, -1);
    drive_frame(256, 3, 320, 1'b1, -1);
    checks++;
    if (rh2 !== 2'd1) begin errors++; $display("FAIL coincide_early: res_h=%0d expected 1", rh2); end
    drive_frame(256, 3, 320, 1'b1, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd2) begin
      errors++; $display("FAIL coincide_fold: commit=%0d res_h=%0d expected 1/2", c2, rh2);
    end
    vif.h40corr_req = 1'b1;
    drive_frame(600, 2, 600, 1'b0, -1);
    drive_frame(600, 2, 600, 1'b0, -1);
    drive_frame(600, 2, 600, 1'b0, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd3) begin
      errors++; $display("FAIL pcnt_saturate: commit=%0d res_h=%0d expected 1/3", c2, rh2);
    end
    vif.h40corr_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_frame(256, 3, 256, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, 100);
    checks++;
    if (rst_snap !== 9'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %b expected 0", rst_snap);
    end
    checks++;
    if (c2 !== 1'b0 || rh2 !== 2'd0) begin
      errors++; $display("FAIL reset_partial_drop: commit=%0d res_h=%0d expected 0/0", c2, rh2);
    end
    drive_frame(256, 3, 256, 1'b0, -1);
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (c2 !== 1'b0 || rh2 !== 2'd0) begin
      errors++; $display("FAIL reset_recount_early: commit=%0d res_h=%0d expected 0/0", c2, rh2);
    end
    drive_frame(256, 3, 256, 1'b0, -1);
    checks++;
    if (c2 !== 1'b1 || rh2 !== 2'd1 || rv2 !== 2'd2) begin
      errors++; $display("FAIL reset_recommit: commit=%0d res_h=%0d res_v=%0d expected 1/1/2", c2, rh2, rv2);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    vif.ce_pix       = 1'b0;
    vif.vdp_de_h     = 1'b0;
    vif.vdp_de_v     = 1'b0;
    vif.hs_in        = 1'b1;
    vif.vs_in        = 1'b1;
    vif.vdp_intfield = 1'b0;
    vif.vdp_m2       = 1'b1;
    vif.vdp_m5       = 1'b1;
    vif.border_req   = 1'b0;
    vif.h40corr_req  = 1'b0;
    rst_snap         = '1;

    test_reset();
    test_h40_lock();
    test_h32_interleave();
    test_h40corr();
    test_blank_interlace();
    test_boundary();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
